uart_rx_cfg: RTL and testbench
==============================

// Module: uart_rx_cfg
// PURPOSE
//  Runtime-configurable UART receiver: 5..MaxDataW data bits, optional even/odd parity, 1 or 2 stop bits.
//  Majority-of-3 samples per bit at a parametrised oversampling rate.
//  Replaces the fixed 8-bit RX path inside the UART core; feeds the RX FIFO and the timeout/break logic.
// PARAMETERS
//  OvsRate   16  ticks of tick_ovs_i per bit; even, >=4; Half = OvsRate/2
//  MaxDataW  9   widest supported character, 5..9
// PORTS
//  clk_i         in   1          clock
//  rst_ni        in   1          reset, asynchronous, active-low
//  rx_enable_i   in   1          receiver enable
//  tick_ovs_i    in   1          oversample tick, one-cycle pulse
//  rx_i          in   1          serial input, already 2-flop synchronised
//  data_len_i    in   4          data bits per char; <5 -> 5, >MaxDataW -> MaxDataW
//  parity_en_i   in   1          parity bit present
//  parity_odd_i  in   1          1 = odd parity, 0 = even parity
//  stop2_i       in   1          two stop bits
//  rx_valid_o    out  1          one-cycle pulse: character complete
//  rx_data_o     out  MaxDataW   LSB-first data, right-aligned, unused MSBs 0
//  parity_err_o  out  1          qualifies rx_valid_o
//  frame_err_o   out  1          qualifies rx_valid_o
//  break_o       out  1          line break active (level)
//  idle_o        out  1          FSM in IDLE
//  tick_baud_o   out  1          pulse at cnt==Half of every bit while receiving
// BEHAVIOUR
//  Reset values: all outputs 0, except idle_o = 1. FSM = IDLE. cnt = 0.
//  FSM: IDLE -> START -> DATA -> [PARITY] -> STOP1 -> [STOP2] -> IDLE.
//  cnt advances only on tick_ovs_i and wraps at OvsRate-1.
//  IDLE: tick with rx_i=0 -> START, cnt=0. Latch data_len/parity/stop2 into shadow regs here.
//  - Config changes mid-character have no effect.
//  Sampling: rx_i captured at cnt = Half-1, Half, Half+1. Bit value = majority of the 3.
//  Bit period ends at cnt == OvsRate-1.
//  START: majority 1 at bit end -> false start, back to IDLE, no rx_valid_o.
//  DATA: shift LSB first; bit counter ends at the latched length.
//  PARITY: err = ^data ^ pbit ^ parity_odd.
//  STOP1: decided at cnt==Half+1, not at bit end, so a back-to-back start edge is caught.
//  - If stop2 latched -> STOP2, same rule. Otherwise -> IDLE.
//  - Majority 0 in any stop bit -> frame error.
//  Outputs on the final stop decision: in the next clk, rx_valid_o=1 for 1 cycle.
//  - rx_data_o, parity_err_o and frame_err_o are registered and held until the next rx_valid_o.
//  rx_enable_i=0: FSM -> IDLE and cnt -> 0 synchronously; partial char dropped, no rx_valid_o.
//  - Held data/err outputs keep their values.
//  tick_ovs_i absent: FSM frozen; no timeout inside this block.
// CONFIGURATION
//  UART_RX_BREAK_EN defined:
//  - Char with data==0 and frame_err -> break_o=1 in the same cycle as rx_valid_o.
//  - Stays 1 until the first tick with rx_i=1.
//  - While break_o=1, start detection is suppressed.
//  UART_RX_BREAK_EN undefined: break_o tied 0; all-zero frame-error chars are reported as ordinary chars.
// STRUCTURE
//  uart_rx_pkg: rx_state_e enum (IDLE, START, DATA, PARITY, STOP1, STOP2).
//  - Also: DataLenMin=5 and the clamp function for data_len_i.
//  Sub-module uart_rx_bitsampler: owns cnt, the three sample flops and the majority vote.
//  - Outputs: bit_mid (cnt==Half+1), bit_end, bit_val, tick_baud.
//  FSM, shifter, parity and break logic stay in uart_rx_cfg.
// TESTING (OvsRate=16, MaxDataW=9; 1 bit = 16 ticks)
//  8N1, send 0xA5 -> single rx_valid_o, rx_data_o=9'h0A5, parity_err_o=0, frame_err_o=0.
//  7 bits, even parity, send 0x3C with parity bit 1 -> rx_data_o=9'h03C, parity_err_o=1.
//  9 bits, stop2, send 0x1FF, 2nd stop bit low -> rx_data_o=9'h1FF, frame_err_o=1.
//  rx_i low for 3 ticks then high -> no rx_valid_o, idle_o back to 1 by the end of the start bit.
//  8N1 0x55; invert rx_i for 1 tick at cnt==Half in bit 3 -> rx_data_o=9'h055 (majority vote).
//  rx_i low for 30 bit times, 8N1:
//  - With macro: rx_valid_o with data 0 and frame_err_o=1; break_o rises with it and drops on the first rx_i=1 tick; no second char.
//  - Without macro: repeated data-0 frame errors, break_o=0.
//  Toggle rx_enable_i low mid-DATA -> FSM returns to IDLE, no rx_valid_o.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the configurable UART receiver.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_e;

    localparam int unsigned DataLenMin = 5;

    // Out-of-range character lengths saturate to the supported window.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input int unsigned max_len);
        if (len < 4'(DataLenMin)) return 4'(DataLenMin);
        if (len > 4'(max_len)) return 4'(max_len);
        return len;
    endfunction

endpackage

// File: rtl/uart_rx_bitsampler.sv
// Oversample counter, three mid-bit sample flops and majority vote for one bit cell.
module uart_rx_bitsampler #(
    parameter int unsigned OvsRate = 16
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear,
    input  logic tick,
    input  logic rx,
    output logic bit_mid,
    output logic bit_end,
    output logic bit_val,
    output logic tick_baud
);

    localparam int unsigned Half = OvsRate / 2;
    localparam int unsigned CntW = $clog2(OvsRate);

    logic [CntW-1:0] cnt_q;
    logic [2:0]      smp_q;
    logic            third;
    logic            run_tick;

    assign run_tick = tick && !clear;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            smp_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= (cnt_q == CntW'(OvsRate - 1)) ? '0 : cnt_q + CntW'(1);
            if (cnt_q == CntW'(Half - 1)) smp_q[0] <= rx;
            if (cnt_q == CntW'(Half))     smp_q[1] <= rx;
            if (cnt_q == CntW'(Half + 1)) smp_q[2] <= rx;
        end
    end

    // At the third sample point the vote uses the live input so decisions need no extra cycle.
    assign third     = (cnt_q == CntW'(Half + 1)) ? rx : smp_q[2];
    assign bit_val   = (smp_q[0] & smp_q[1]) | (smp_q[0] & third) | (smp_q[1] & third);
    assign bit_mid   = run_tick && (cnt_q == CntW'(Half + 1));
    assign bit_end   = run_tick && (cnt_q == CntW'(OvsRate - 1));
    assign tick_baud = run_tick && (cnt_q == CntW'(Half));

endmodule

// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver (5..MaxDataW bits, optional parity, 1/2 stop bits).
// Define UART_RX_BREAK_EN to enable line-break detection on break_o.
module uart_rx_cfg
    import uart_rx_pkg::*;
#(
    parameter int unsigned OvsRate  = 16,
    parameter int unsigned MaxDataW = 9
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                rx_enable_i,
    input  logic                tick_ovs_i,
    input  logic                rx_i,
    input  logic [3:0]          data_len_i,
    input  logic                parity_en_i,
    input  logic                parity_odd_i,
    input  logic                stop2_i,
    output logic                rx_valid_o,
    output logic [MaxDataW-1:0] rx_data_o,
    output logic                parity_err_o,
    output logic                frame_err_o,
    output logic                break_o,
    output logic                idle_o,
    output logic                tick_baud_o
);

    rx_state_e           state_q, state_d;
    logic                bit_mid, bit_end, bit_val;
    logic                start_det, start_block, finish, ferr_fin;
    logic [3:0]          len_q, bit_cnt_q;
    logic                par_en_q, par_odd_q, stop2_q;
    logic [MaxDataW-1:0] shift_q;
    logic                perr_q, ferr_q;
    logic                rx_valid_q, parity_err_q, frame_err_q;
    logic [MaxDataW-1:0] rx_data_q;

    uart_rx_bitsampler #(.OvsRate(OvsRate)) u_sampler (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear     (!rx_enable_i || state_q == IDLE),
        .tick      (tick_ovs_i),
        .rx        (rx_i),
        .bit_mid   (bit_mid),
        .bit_end   (bit_end),
        .bit_val   (bit_val),
        .tick_baud (tick_baud_o)
    );

    assign start_det = rx_enable_i && tick_ovs_i && !rx_i && (state_q == IDLE) && !start_block;
    assign ferr_fin  = ferr_q | !bit_val;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        finish  = 1'b0;
        if (!rx_enable_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:   if (start_det) state_d = START;
                START:  if (bit_end) state_d = bit_val ? IDLE : DATA;
                DATA:   if (bit_end && bit_cnt_q == len_q - 4'd1) state_d = par_en_q ? PARITY : STOP1;
                PARITY: if (bit_end) state_d = STOP1;
                // Stop bits resolve at mid-bit so an immediately following start edge is seen.
                STOP1:  if (bit_mid) begin
                            state_d = stop2_q ? STOP2 : IDLE;
                            finish  = !stop2_q;
                        end
                STOP2:  if (bit_mid) begin
                            state_d = IDLE;
                            finish  = 1'b1;
                        end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            len_q        <= 4'(DataLenMin);
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            stop2_q      <= 1'b0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            rx_valid_q   <= 1'b0;
            rx_data_q    <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_valid_q <= finish;
            if (start_det) begin
                len_q     <= clamp_len(data_len_i, MaxDataW);
                par_en_q  <= parity_en_i;
                par_odd_q <= parity_odd_i;
                stop2_q   <= stop2_i;
                bit_cnt_q <= '0;
                shift_q   <= '0;
                perr_q    <= 1'b0;
                ferr_q    <= 1'b0;
            end
            if (state_q == DATA && bit_end) begin
                shift_q[bit_cnt_q] <= bit_val;
                bit_cnt_q          <= bit_cnt_q + 4'd1;
            end
            if (state_q == PARITY && bit_end) perr_q <= ^shift_q ^ bit_val ^ par_odd_q;
            if (state_q == STOP1 && bit_mid)  ferr_q <= !bit_val;
            if (finish) begin
                rx_data_q    <= shift_q;
                parity_err_q <= perr_q;
                frame_err_q  <= ferr_fin;
            end
        end
    end

`ifdef UART_RX_BREAK_EN
    logic break_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                       break_q <= 1'b0;
        else if (finish && shift_q == '0 && ferr_fin)      break_q <= 1'b1;
        else if (tick_ovs_i && rx_i)                       break_q <= 1'b0;
    end

    assign start_block = break_q;
    assign break_o     = break_q;
`else
    assign start_block = 1'b0;
    assign break_o     = 1'b0;
`endif

    assign rx_valid_o   = rx_valid_q;
    assign rx_data_o    = rx_data_q;
    assign parity_err_o = parity_err_q;
    assign frame_err_o  = frame_err_q;
    assign idle_o       = (state_q == IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: frames are driven tick by tick, expected characters queued.
module tb_uart_rx_cfg;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       rx_enable_i;
    logic       tick_ovs_i;
    logic       rx_i;
    logic [3:0] data_len_i;
    logic       parity_en_i;
    logic       parity_odd_i;
    logic       stop2_i;
    logic       rx_valid_o;
    logic [8:0] rx_data_o;
    logic       parity_err_o;
    logic       frame_err_o;
    logic       break_o;
    logic       idle_o;
    logic       tick_baud_o;

    // Entry layout: {break, frame_err, parity_err, data[8:0]}
    logic [11:0] exp_q[$];
    int total = 0;
    int bad   = 0;
    int baud_cnt = 0;

    uart_rx_cfg #(.OvsRate(16), .MaxDataW(9)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .rx_enable_i  (rx_enable_i),
        .tick_ovs_i   (tick_ovs_i),
        .rx_i         (rx_i),
        .data_len_i   (data_len_i),
        .parity_en_i  (parity_en_i),
        .parity_odd_i (parity_odd_i),
        .stop2_i      (stop2_i),
        .rx_valid_o   (rx_valid_o),
        .rx_data_o    (rx_data_o),
        .parity_err_o (parity_err_o),
        .frame_err_o  (frame_err_o),
        .break_o      (break_o),
        .idle_o       (idle_o),
        .tick_baud_o  (tick_baud_o)
    );

    always #5 clk_i = ~clk_i;

    // One oversample tick spans two clocks; outputs are observed on each falling edge.
    task automatic do_tick(input logic rx, input logic en);
        logic [11:0] got, exp_v;
        for (int h = 0; h < 2; h++) begin
            @(posedge clk_i);
            #1;
            if (h == 0) begin
                rx_i        = rx;
                rx_enable_i = en;
                tick_ovs_i  = 1'b1;
            end else begin
                tick_ovs_i = 1'b0;
            end
            @(negedge clk_i);
            if (tick_baud_o) baud_cnt++;
            if (rx_valid_o) begin
                total++;
                got = {break_o, frame_err_o, parity_err_o, rx_data_o};
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_char: got brk=%b ferr=%b perr=%b data=%h, required no char",
                             got[11], got[10], got[9], got[8:0]);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got !== exp_v) begin
                        bad++;
                        $display("FAIL char: got brk=%b ferr=%b perr=%b data=%h, required brk=%b ferr=%b perr=%b data=%h",
                                 got[11], got[10], got[9], got[8:0], exp_v[11], exp_v[10], exp_v[9], exp_v[8:0]);
                    end
                end
            end
        end
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) do_tick(1'b1, 1'b1);
    endtask

    // par < 0 omits the parity bit; last_stop is the value of the final stop bit.
    task automatic send_frame(input logic [8:0] data, input int nbits, input int par, input int nstop,
                              input logic last_stop, input int g_idx, input bit chg_cfg);
        logic fb[$];
        logic v;
        fb.push_back(1'b0);
        for (int i = 0; i < nbits; i++) fb.push_back(data[i]);
        if (par >= 0) fb.push_back(par[0]);
        if (nstop == 2) fb.push_back(1'b1);
        fb.push_back(last_stop);
        for (int b = 0; b < fb.size(); b++) begin
            for (int j = 0; j < 16; j++) begin
                v = fb[b];
                if (b == g_idx && j == 9) v = ~v;
                if (chg_cfg && b == 2 && j == 0) begin
                    data_len_i  = 4'd5;
                    parity_en_i = 1'b1;
                    stop2_i     = 1'b1;
                end
                do_tick(v, 1'b1);
            end
        end
    endtask

    task automatic set_cfg(input logic [3:0] len, input logic pen, input logic podd, input logic s2);
        data_len_i   = len;
        parity_en_i  = pen;
        parity_odd_i = podd;
        stop2_i      = s2;
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_missing: %0d chars still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset;
        rst_ni      = 1'b0;
        rx_enable_i = 1'b1;
        tick_ovs_i  = 1'b0;
        rx_i        = 1'b1;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        total++; if (rx_valid_o !== 1'b0)   begin bad++; $display("FAIL reset_valid: got %b, required 0", rx_valid_o); end
        total++; if (rx_data_o !== 9'h000)  begin bad++; $display("FAIL reset_data: got %h, required 000", rx_data_o); end
        total++; if (parity_err_o !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b, required 0", parity_err_o); end
        total++; if (frame_err_o !== 1'b0)  begin bad++; $display("FAIL reset_ferr: got %b, required 0", frame_err_o); end
        total++; if (break_o !== 1'b0)      begin bad++; $display("FAIL reset_break: got %b, required 0", break_o); end
        total++; if (idle_o !== 1'b1)       begin bad++; $display("FAIL reset_idle: got %b, required 1", idle_o); end
        total++; if (tick_baud_o !== 1'b0)  begin bad++; $display("FAIL reset_baud: got %b, required 0", tick_baud_o); end
        rst_ni = 1'b1;
        idle_ticks(4);
    endtask

    task automatic test_8n1;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        baud_cnt = 0;
        exp_q.push_back({3'b000, 9'h0A5});
        send_frame(9'h0A5, 8, -1, 1, 1'b1, -1, 1'b0);
        idle_ticks(4);
        check_drained("8n1");
        total++;
        if (baud_cnt != 10) begin
            bad++;
            $display("FAIL baud_pulses: got %0d, required 10", baud_cnt);
        end
        total++;
        if (idle_o !== 1'b1) begin bad++; $display("FAIL 8n1_idle: got %b, required 1", idle_o); end
    endtask

    task automatic test_parity;
        set_cfg(4'd7, 1'b1, 1'b0, 1'b0);
        exp_q.push_back({3'b001, 9'h03C});
        send_frame(9'h03C, 7, 1, 1, 1'b1, -1, 1'b0);
        idle_ticks(4);
        set_cfg(4'd7, 1'b1, 1'b1, 1'b0);
        exp_q.push_back({3'b000, 9'h03C});
        send_frame(9'h03C, 7, 1, 1, 1'b1, -1, 1'b0);
        idle_ticks(4);
        check_drained("parity");
    endtask

    task automatic test_stop2;
        set_cfg(4'd9, 1'b0, 1'b0, 1'b1);
        exp_q.push_back({3'b010, 9'h1FF});
        send_frame(9'h1FF, 9, -1, 2, 1'b0, -1, 1'b0);
        idle_ticks(20);
        exp_q.push_back({3'b000, 9'h0F0});
        send_frame(9'h0F0, 9, -1, 2, 1'b1, -1, 1'b0);
        idle_ticks(4);
        check_drained("stop2");
    endtask

    task automatic test_len_clamp;
        set_cfg(4'd3, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({3'b000, 9'h015});
        send_frame(9'h015, 5, -1, 1, 1'b1, -1, 1'b0);
        idle_ticks(4);
        set_cfg(4'd15, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({3'b000, 9'h1A3});
        send_frame(9'h1A3, 9, -1, 1, 1'b1, -1, 1'b0);
        idle_ticks(4);
        check_drained("len_clamp");
    endtask

    task automatic test_false_start;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) do_tick(1'b0, 1'b1);
        total++;
        if (idle_o !== 1'b0) begin bad++; $display("FAIL false_start_busy: got idle=%b, required 0", idle_o); end
        idle_ticks(16);
        total++;
        if (idle_o !== 1'b1) begin bad++; $display("FAIL false_start_idle: got idle=%b, required 1", idle_o); end
        check_drained("false_start");
    endtask

    task automatic test_glitch;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({3'b000, 9'h055});
        send_frame(9'h055, 8, -1, 1, 1'b1, 4, 1'b0);
        idle_ticks(4);
        check_drained("glitch");
    endtask

    task automatic test_cfg_change;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({3'b000, 9'h0A5});
        send_frame(9'h0A5, 8, -1, 1, 1'b1, -1, 1'b1);
        idle_ticks(4);
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        idle_ticks(2);
        check_drained("cfg_change");
    endtask

    task automatic test_back_to_back;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        exp_q.push_back({3'b000, 9'h012});
        exp_q.push_back({3'b000, 9'h034});
        send_frame(9'h012, 8, -1, 1, 1'b1, -1, 1'b0);
        send_frame(9'h034, 8, -1, 1, 1'b1, -1, 1'b0);
        idle_ticks(4);
        check_drained("back_to_back");
    endtask

    task automatic test_enable_abort;
        logic [3:0] part;
        part = 4'b0101;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 16; j++) do_tick(1'b0, 1'b1);
        for (int b = 0; b < 3; b++)
            for (int j = 0; j < 16; j++) do_tick(part[b], 1'b1);
        do_tick(1'b1, 1'b0);
        total++;
        if (idle_o !== 1'b1) begin bad++; $display("FAIL abort_idle: got %b, required 1", idle_o); end
        total++;
        if (rx_data_o !== 9'h034) begin bad++; $display("FAIL abort_held_data: got %h, required 034", rx_data_o); end
        idle_ticks(20);
        check_drained("abort");
        exp_q.push_back({3'b000, 9'h0C3});
        send_frame(9'h0C3, 8, -1, 1, 1'b1, -1, 1'b0);
        idle_ticks(4);
        check_drained("abort_recover");
    endtask

    task automatic test_break;
        set_cfg(4'd8, 1'b0, 1'b0, 1'b0);
`ifdef UART_RX_BREAK_EN
        exp_q.push_back({3'b110, 9'h000});
`else
        for (int i = 0; i < 3; i++) exp_q.push_back({3'b010, 9'h000});
`endif
        for (int i = 0; i < 30 * 16; i++) do_tick(1'b0, 1'b1);
        do_tick(1'b0, 1'b0);
        check_drained("break_chars");
        total++;
`ifdef UART_RX_BREAK_EN
        if (break_o !== 1'b1) begin bad++; $display("FAIL break_level: got %b, required 1", break_o); end
`else
        if (break_o !== 1'b0) begin bad++; $display("FAIL break_level: got %b, required 0", break_o); end
`endif
        do_tick(1'b1, 1'b1);
        total++;
        if (break_o !== 1'b0) begin bad++; $display("FAIL break_release: got %b, required 0", break_o); end
        idle_ticks(20);
        check_drained("break_tail");
    endtask

    initial begin
        test_reset;
        test_8n1;
        test_parity;
        test_stop2;
        test_len_clamp;
        test_false_start;
        test_glitch;
        test_cfg_change;
        test_back_to_back;
        test_enable_abort;
        test_break;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
